// File: rtl/mem_exc_ctrl.sv
// mem_exc_ctrl: MEM-stage exception controller sitting in front of cp0.
// Picks the single winning exception for the MEM instruction and applies
// WB-stage cp0 write bypass to Status/Cause/EPC. It drives the cp0 exception
// inputs, synchronises the hardware interrupt lines, and issues the pipeline
// flush together with the redirect PC.
// Optional feature: define MEM_EXC_TIMER_INT_EN to add the Count/Compare
// timer interrupt on int_o[5]. Without it, that bit is tied low.
module mem_exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid_i,
  input  logic        stall_i,
  input  logic [31:0] pc_i,
  input  logic        in_delayslot_i,
  input  logic [7:0]  exc_flags_i,
  input  logic [31:0] mem_addr_i,
  input  logic [5:0]  ext_int_i,
  input  logic [31:0] count_i,
  input  logic [31:0] compare_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_wdata_i,
  output logic [5:0]  int_o,
  output logic [31:0] excepttype_o,
  output logic [31:0] exc_pc_o,
  output logic        exc_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

  localparam int              CNT_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES - 1);

  localparam logic [4:0] ADDR_COMPARE = 5'd11;
  localparam logic [4:0] ADDR_STATUS  = 5'd12;
  localparam logic [4:0] ADDR_CAUSE   = 5'd13;
  localparam logic [4:0] ADDR_EPC     = 5'd14;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [31:0]       new_pc_reg, new_pc_next;

  logic [31:0] eff_status, eff_cause, eff_epc;
  logic        int_req;
  logic        can_take, exc_any, take;
  logic [31:0] exc_code;
  logic        exc_is_eret;
  logic [31:0] take_pc;
  logic        timer_int;
  logic [5:0]  sync_reg [SYNC_STAGES];

  // A WB write to Status/Cause/EPC in this cycle overrides the stale cp0 value.
  assign eff_status = (wb_cp0_we_i && wb_cp0_waddr_i == ADDR_STATUS) ? wb_cp0_wdata_i : status_i;
  assign eff_cause  = (wb_cp0_we_i && wb_cp0_waddr_i == ADDR_CAUSE)  ? wb_cp0_wdata_i : cause_i;
  assign eff_epc    = (wb_cp0_we_i && wb_cp0_waddr_i == ADDR_EPC)    ? wb_cp0_wdata_i : epc_i;

  // Interrupt needs a pending unmasked line, IE set and EXL clear.
  assign int_req = (|(eff_cause[15:8] & eff_status[15:8])) && eff_status[0] && !eff_status[1];

  assign can_take = (state_reg == IDLE) && inst_valid_i && !stall_i && !rst;
  assign exc_any  = int_req || (|exc_flags_i);
  assign take     = can_take && exc_any;

  // Resolve the single winning exception code in priority order.
  always_comb begin
    exc_code    = '0;
    exc_is_eret = 1'b0;
    if (int_req)             exc_code[7:0] = 8'h01;
    else if (exc_flags_i[0]) exc_code[13]  = 1'b1;  // adel_if
    else if (exc_flags_i[1]) exc_code[10]  = 1'b1;  // ri
    else if (exc_flags_i[2]) exc_code[16]  = 1'b1;  // ov
    else if (exc_flags_i[3]) exc_code[9]   = 1'b1;  // brk
    else if (exc_flags_i[4]) exc_code[8]   = 1'b1;  // syscall
    else if (exc_flags_i[5]) exc_code[14]  = 1'b1;  // adel
    else if (exc_flags_i[6]) exc_code[15]  = 1'b1;  // ades
    else if (exc_flags_i[7]) begin                  // eret
      exc_code[12] = 1'b1;
      exc_is_eret  = 1'b1;
    end
  end

  assign take_pc = exc_is_eret ? eff_epc : EXC_VECTOR;

  assign exc_pc_o        = pc_i;
  assign exc_delayslot_o = in_delayslot_i;
  assign bad_addr_o      = exc_flags_i[0] ? pc_i : mem_addr_i;

  // Flush sequencer: next state and the exception/flush outputs.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    new_pc_next  = new_pc_reg;
    flush_o      = 1'b0;
    excepttype_o = '0;
    new_pc_o     = new_pc_reg;
    case (state_reg)
      IDLE: begin
        if (take) begin
          flush_o      = 1'b1;
          excepttype_o = exc_code;
          new_pc_o     = take_pc;
          new_pc_next  = take_pc;
          if (FLUSH_CYCLES > 1) begin
            state_next = FLUSH;
            cnt_next   = CNT_INIT;
          end
        end
      end
      FLUSH: begin
        flush_o  = 1'b1;
        cnt_next = cnt_reg - 1'b1;
        if (cnt_next == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Flush sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      new_pc_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      new_pc_reg <= new_pc_next;
    end
  end

  // Multi-flop synchroniser for the asynchronous interrupt lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= '0;
    end else begin
      sync_reg[0] <= ext_int_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
    end
  end

`ifdef MEM_EXC_TIMER_INT_EN
  logic timer_int_reg;

  // Timer interrupt: set on Count==Compare (Compare nonzero), cleared by a Compare write.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_int_reg <= 1'b0;
    end else if (wb_cp0_we_i && wb_cp0_waddr_i == ADDR_COMPARE) begin
      timer_int_reg <= 1'b0;
    end else if (count_i == compare_i && compare_i != '0) begin
      timer_int_reg <= 1'b1;
    end
  end

  assign timer_int = timer_int_reg;
`else
  logic unused_timer;
  assign timer_int    = 1'b0;
  assign unused_timer = &{1'b0, count_i, compare_i};
`endif

  assign int_o = sync_reg[SYNC_STAGES-1] | {timer_int, 5'b0};

  // Only IM/IP, EXL and IE participate in the interrupt decision.
  logic unused_bits;
  assign unused_bits = &{1'b0, eff_status[31:16], eff_status[7:2], eff_cause[31:16], eff_cause[7:0]};

endmodule
